// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_ADDR_W = 3;
    localparam int ZERO_IDX   = 0;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_entry.sv
// One register of the file: data word plus its pending-write flag.
module regfile_entry
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] wd,
    input  logic             set_pend,
    input  logic             clr_pend,
    output logic [WIDTH-1:0] data,
    output logic             pend
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            pend <= 1'b0;
        end else begin
            if (we) begin
                data <= wd;
            end
            // A new producer supersedes the one completing this cycle.
            if (set_pend) begin
                pend <= 1'b1;
            end else if (clr_pend) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_scb.sv
// Register file with one write port, two read ports, optional bypass and
// zero register, plus a per-register pending-write scoreboard for hazard detection.
module regfile_scb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read1RegSel,
    input  logic [ADDR_W-1:0] read2RegSel,
    input  logic [ADDR_W-1:0] writeRegSel,
    input  logic [WIDTH-1:0]  writeData,
    input  logic              writeEn,
    input  logic              issueEn,
    input  logic [ADDR_W-1:0] issueSel,
    output logic [WIDTH-1:0]  read1Data,
    output logic [WIDTH-1:0]  read2Data,
    output logic              read1Pend,
    output logic              read2Pend,
    output logic              anyPend,
    output logic              err
);

    localparam int DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] ZSEL = ADDR_W'(ZERO_IDX);

    logic             wr_ok;
    logic             iss_ok;
    logic [DEPTH-1:0] wr_hot;
    logic [DEPTH-1:0] iss_hot;
    logic [DEPTH-1:0] pend_q;
    logic [WIDTH-1:0] reg_q [DEPTH];
    logic             wr_bad;
    logic             iss_bad;

    // Operations aimed at the hard-wired zero register are dropped entirely.
    assign wr_ok  = writeEn && !((ZERO_REG != 0) && (writeRegSel == ZSEL));
    assign iss_ok = issueEn && !((ZERO_REG != 0) && (issueSel == ZSEL));

    always_comb begin
        wr_hot  = '0;
        iss_hot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_hot[i]  = wr_ok  && (writeRegSel == ADDR_W'(i));
            iss_hot[i] = iss_ok && (issueSel    == ADDR_W'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        regfile_entry #(
            .WIDTH (WIDTH)
        ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .we       (wr_hot[g]),
            .wd       (writeData),
            .set_pend (iss_hot[g]),
            .clr_pend (wr_hot[g]),
            .data     (reg_q[g]),
            .pend     (pend_q[g])
        );
    end

    always_comb begin
        read1Data = reg_q[read1RegSel];
        read2Data = reg_q[read2RegSel];
        read1Pend = pend_q[read1RegSel];
        read2Pend = pend_q[read2RegSel];
        if ((ZERO_REG != 0) && (read1RegSel == ZSEL)) begin
            read1Data = '0;
        end
        if ((ZERO_REG != 0) && (read2RegSel == ZSEL)) begin
            read2Data = '0;
        end
        // wr_ok already excludes the zero register, so bypass never hits it.
        if ((BYPASS != 0) && wr_ok && (writeRegSel == read1RegSel)) begin
            read1Data = writeData;
            read1Pend = 1'b0;
        end
        if ((BYPASS != 0) && wr_ok && (writeRegSel == read2RegSel)) begin
            read2Data = writeData;
            read2Pend = 1'b0;
        end
    end

    assign anyPend = |pend_q;

    assign wr_bad  = wr_ok && !pend_q[writeRegSel] && !(iss_ok && (issueSel == writeRegSel));
    assign iss_bad = iss_ok && pend_q[issueSel] && !(wr_ok && (writeRegSel == issueSel));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (wr_bad || iss_bad) begin
            err <= 1'b1;
        end
    end

endmodule

// File: doc/regfile_scb.md
# regfile_scb

Parametrised successor to the 8x16 processor register file. Provides DEPTH = 2^ADDR_W registers of WIDTH bits with one write port and two read ports, plus:
- optional write-to-read bypass;
- optional hard-wired zero register;
- per-register pending-write scoreboard for pipeline hazard detection;
- sticky protocol-error flag.

It sits in decode: reads feed the execute operands, the write port is driven by writeback, and the issue port is driven by the decode stage when it dispatches an instruction with a destination register.

## Interface
Parameters:
- WIDTH, 16, data width of each register
- ADDR_W, 3, select width; DEPTH = 2^ADDR_W
- BYPASS, 1, 1 = same-cycle write data forwarded to reads and pending flags
- ZERO_REG, 0, 1 = register 0 reads as zero, ignores writes, never pending

Ports (clock and reset first):
- clk  in  1  single clock, all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- read1RegSel  in  ADDR_W  read port 1 select
- read2RegSel  in  ADDR_W  read port 2 select
- writeRegSel  in  ADDR_W  write select
- writeData  in  WIDTH  write data
- writeEn  in  1  write strobe
- issueEn  in  1  mark issueSel pending
- issueSel  in  ADDR_W  register whose write is now outstanding
- read1Data  out  WIDTH  port 1 data
- read2Data  out  WIDTH  port 2 data
- read1Pend  out  1  read1RegSel has an outstanding write
- read2Pend  out  1  read2RegSel has an outstanding write
- anyPend  out  1  OR of all pending bits
- err  out  1  sticky protocol error

## Operation
- Storage: DEPTH registers. A write updates reg[writeRegSel] on the rising edge when writeEn = 1.
- Reads are combinational: readNData = reg[readNRegSel].
- Read bypass: when BYPASS = 1, writeEn = 1 and writeRegSel == readNRegSel, readNData = writeData in the same cycle. Both ports bypass independently.
- ZERO_REG = 1: reads of index 0 return 0; writes to 0 are dropped; issue to 0 is dropped; bypass never applies to index 0.
- Scoreboard: one pending bit per register.
  - Set on an edge with issueEn = 1 at issueSel.
  - Cleared on an edge with writeEn = 1 at writeRegSel.
  - Same register issued and written in the same cycle: set wins, because a new producer supersedes the completing one.
- readNPend = pending[readNRegSel]. With BYPASS = 1, it is forced to 0 when the same-cycle write targets that register.
- anyPend is the OR of all pending bits, with no bypass.
- Error conditions set err on the edge; err stays 1 until rst:
  - writeEn to a register that is not pending and not being issued the same cycle (unexpected writeback);
  - issueEn to a register already pending with no same-cycle write to it (WAW overlap).
- Operations that ZERO_REG drops never raise err.

## Timing
- Reset (async, immediate): all registers 0, all pending bits 0, err 0. Therefore read1Data = read2Data = 0, read1Pend = read2Pend = anyPend = 0.
- Reset asserted mid-cycle overrides any write or issue in flight; nothing is retained.
- Write latency: 1 edge to storage, 0 cycles to the read ports via bypass.
- Issue latency: pending is visible on readNPend the cycle after issueEn.
- Read ports and pending outputs are purely combinational from state plus same-cycle write inputs; there is no output register.
- Writes and issues in the same cycle to different registers are fully independent.

## Structure
- Shared package regfile_pkg holds:
  - default WIDTH and ADDR_W constants;
  - a DEPTH derivation function (1 << ADDR_W);
  - the index constant ZERO_IDX = 0.
- Sub-module regfile_entry: one WIDTH-bit register with async active-high reset, write enable, pending bit, and set/clear priority logic. It is instantiated DEPTH times with a generate loop.
- Top level contains:
  - the write and issue one-hot decoders;
  - two read muxes with bypass;
  - the pending muxes;
  - the err accumulation.

## Test plan
- Reset then read: assert rst, read every index on both ports -> all data 0, all pends 0, err 0.
- Write/readback with bypass: writeEn = 1, writeRegSel = 5, writeData = 16'hBEEF, read1RegSel = 5.
  - BYPASS = 1 -> read1Data = 16'hBEEF in the same cycle.
  - BYPASS = 0 -> read1Data = 16'hBEEF only on the next cycle.
  - In both cases read2RegSel = 5 returns 16'hBEEF on the next cycle.
- Scoreboard lifecycle:
  - issue 3 -> next cycle read1RegSel = 3 shows read1Pend = 1 and anyPend = 1;
  - write 3 with 16'h0042 -> read1Pend = 0 in the same cycle (BYPASS = 1) and anyPend = 0 after the edge; err stays 0.
- Simultaneous issue and write of register 6 while 6 is pending -> 6 remains pending, data is updated, err = 0.
- Protocol errors:
  - writeEn to non-pending register 2 -> err = 1 after the edge and held until rst;
  - separately, issuing 4 twice without a write -> err = 1.
- ZERO_REG = 1 with WIDTH = 32, ADDR_W = 4: write 32'hFFFF_FFFF to 0 and issue 0 -> read 0 = 0, pend = 0, err = 0; register 15 is still writable and readable.
